pong_game_ctrl: RTL

Frame-rate game sequencer for the Pong datapath. It sits between the ball object, the two paddle objects and the score display. It decides when the ball is recentred and launched, and when it may move. It detects paddle hits and asks the ball for a horizontal bounce, detects misses, keeps both scores and declares a winner.

---
 rtl/pong_game_ctrl_if.sv | 24 ++
 rtl/pong_game_ctrl.sv | 162 ++++++++++++++++
 2 files changed

// File: rtl/pong_game_ctrl_if.sv
// Ball/paddle geometry and ball-control strobes shared between the Pong
// game sequencer (master) and the ball object (slave).
interface pong_game_ctrl_if;
  logic signed [11:0] ball_lh;
  logic signed [11:0] ball_rh;
  logic signed [11:0] ball_tv;
  logic signed [11:0] ball_bv;
  logic signed [11:0] pad_l_tv;
  logic signed [11:0] pad_r_tv;
  logic               ball_load;
  logic               ball_en;
  logic               bounce_x;
  logic        [1:0]  serve_dir;

  modport master (
    input  ball_lh, ball_rh, ball_tv, ball_bv, pad_l_tv, pad_r_tv,
    output ball_load, ball_en, bounce_x, serve_dir
  );

  modport slave (
    output ball_lh, ball_rh, ball_tv, ball_bv, pad_l_tv, pad_r_tv,
    input  ball_load, ball_en, bounce_x, serve_dir
  );
endinterface

// File: rtl/pong_game_ctrl.sv
// Frame-rate Pong sequencer: serve hold, paddle-hit bounce, miss scoring,
// point pause and win detection. Decisions are taken only in fsync cycles.
module pong_game_ctrl #(
  parameter int HRES         = 1280,
  parameter int VRES         = 720,
  parameter int PADDLE_W     = 10,
  parameter int PADDLE_LEN   = 100,
  parameter int WIN_SCORE    = 7,
  parameter int SERVE_FRAMES = 60,
  parameter int POINT_FRAMES = 90
) (
  input  logic              pixel_clk,
  input  logic              rst,
  input  logic              fsync,
  input  logic              start,
  pong_game_ctrl_if.master  bus,
  output logic [3:0]        score_l,
  output logic [3:0]        score_r,
  output logic [1:0]        winner,
  output logic [2:0]        state
);

  if (HRES > 2047 || VRES > 2047 || WIN_SCORE < 1 || WIN_SCORE > 15 ||
      SERVE_FRAMES < 1 || SERVE_FRAMES > 255 ||
      POINT_FRAMES < 1 || POINT_FRAMES > 255) begin : g_param_check
    $error("pong_game_ctrl: parameter out of range");
  end

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SERVE = 3'd1,
    PLAY  = 3'd2,
    POINT = 3'd3,
    OVER  = 3'd4
  } state_t;

  typedef enum logic [1:0] {
    HIT_NONE,
    HIT_LEFT,
    HIT_RIGHT
  } hit_t;

  localparam logic signed [12:0] PAD_LEN_M1 = 13'(PADDLE_LEN - 1);
  localparam logic signed [11:0] LEFT_EDGE  = 12'(PADDLE_W - 1);
  localparam logic signed [11:0] RIGHT_EDGE = 12'(HRES - PADDLE_W);
  localparam logic signed [11:0] RIGHT_WALL = 12'(HRES - 1);
  localparam logic        [7:0]  SERVE_LAST = 8'(SERVE_FRAMES - 1);
  localparam logic        [7:0]  POINT_LAST = 8'(POINT_FRAMES - 1);
  localparam logic        [3:0]  WIN        = 4'(WIN_SCORE);

  state_t     st;
  hit_t       last_hit;
  logic [7:0] frame_cnt;
  logic       vtoggle;
  logic       leftward;

  logic signed [12:0] ball_tv13, pad_l_bot, pad_r_bot;
  logic               hit_l, hit_r;

  // Paddle bottoms are formed in 13 bits so a paddle near the top of the
  // signed range cannot wrap negative.
  assign ball_tv13 = $signed({bus.ball_tv[11], bus.ball_tv});
  assign pad_l_bot = $signed({bus.pad_l_tv[11], bus.pad_l_tv}) + PAD_LEN_M1;
  assign pad_r_bot = $signed({bus.pad_r_tv[11], bus.pad_r_tv}) + PAD_LEN_M1;

  assign hit_l = (bus.ball_lh <= LEFT_EDGE) && (bus.ball_bv >= bus.pad_l_tv) &&
                 (ball_tv13 <= pad_l_bot) && (last_hit != HIT_LEFT);
  assign hit_r = (bus.ball_rh >= RIGHT_EDGE) && (bus.ball_bv >= bus.pad_r_tv) &&
                 (ball_tv13 <= pad_r_bot) && (last_hit != HIT_RIGHT);

  assign state = st;

  always_ff @(posedge pixel_clk) begin
    if (rst) begin
      st            <= IDLE;
      bus.ball_load <= 1'b0;
      bus.ball_en   <= 1'b0;
      bus.bounce_x  <= 1'b0;
      bus.serve_dir <= '0;
      score_l       <= '0;
      score_r       <= '0;
      winner        <= '0;
      frame_cnt     <= '0;
      vtoggle       <= 1'b0;
      leftward      <= 1'b0;
      last_hit      <= HIT_NONE;
    end else begin
      bus.ball_load <= 1'b0;
      bus.bounce_x  <= 1'b0;
      if (fsync) begin
        case (st)
          IDLE: begin
            if (start) begin
              score_l       <= '0;
              score_r       <= '0;
              winner        <= '0;
              frame_cnt     <= '0;
              leftward      <= 1'b0;
              bus.ball_load <= 1'b1;
              bus.serve_dir <= {vtoggle, 1'b0};
              vtoggle       <= ~vtoggle;
              last_hit      <= HIT_NONE;
              st            <= SERVE;
            end
          end
          SERVE: begin
            if (frame_cnt == SERVE_LAST) begin
              bus.ball_en <= 1'b1;
              st          <= PLAY;
            end else begin
              frame_cnt <= frame_cnt + 8'd1;
            end
          end
          PLAY: begin
            if (hit_l) begin
              bus.bounce_x <= 1'b1;
              last_hit     <= HIT_LEFT;
            end else if (hit_r) begin
              bus.bounce_x <= 1'b1;
              last_hit     <= HIT_RIGHT;
            end else if (bus.ball_lh == '0) begin
              score_r     <= score_r + 4'd1;
              leftward    <= 1'b1;
              bus.ball_en <= 1'b0;
              frame_cnt   <= '0;
              st          <= POINT;
            end else if (bus.ball_rh == RIGHT_WALL) begin
              score_l     <= score_l + 4'd1;
              leftward    <= 1'b0;
              bus.ball_en <= 1'b0;
              frame_cnt   <= '0;
              st          <= POINT;
            end
          end
          POINT: begin
            if (score_l == WIN) begin
              winner <= 2'b01;
              st     <= OVER;
            end else if (score_r == WIN) begin
              winner <= 2'b10;
              st     <= OVER;
            end else if (frame_cnt == POINT_LAST) begin
              bus.ball_load <= 1'b1;
              bus.serve_dir <= {vtoggle, leftward};
              vtoggle       <= ~vtoggle;
              last_hit      <= HIT_NONE;
              frame_cnt     <= '0;
              st            <= SERVE;
            end else begin
              frame_cnt <= frame_cnt + 8'd1;
            end
          end
          OVER: begin
            if (!start) st <= IDLE;
          end
          default: st <= IDLE;
        endcase
      end
    end
  end

endmodule
